// File: rtl/axi4_slave_mem_if.sv
// AXI4 channel bundle between a master and axi4_slave_mem.
// Clock and reset stay outside the bundle as plain ports.
interface axi4_slave_mem_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ID_WIDTH-1:0]     AWID;
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [7:0]              AWLEN;
    logic [2:0]              AWSIZE;
    logic [1:0]              AWBURST;
    logic                    AWVALID;
    logic                    AWREADY;

    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WLAST;
    logic                    WVALID;
    logic                    WREADY;

    logic [ID_WIDTH-1:0]     BID;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;

    logic [ID_WIDTH-1:0]     ARID;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [7:0]              ARLEN;
    logic [2:0]              ARSIZE;
    logic [1:0]              ARBURST;
    logic                    ARVALID;
    logic                    ARREADY;

    logic [ID_WIDTH-1:0]     RID;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RLAST;
    logic                    RVALID;
    logic                    RREADY;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );
endinterface

// File: rtl/axi4_slave_mem.sv
// AXI4 memory slave: independent write and read FSMs over a word-addressed RAM,
// supporting FIXED/INCR/WRAP bursts, byte strobes and burst-sticky SLVERR.
module axi4_slave_mem #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic            clk,
    input  logic            ARESET_n,
    axi4_slave_mem_if.slave bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(STRB_WIDTH);
    localparam int IDX_WIDTH  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] DEPTH_WORDS = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [2:0]            SIZE_MAX    = 3'(BYTE_SHIFT);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [2:0]            size,
        input logic [1:0]            burst,
        input logic [7:0]            len
    );
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] wrap_mask;
        logic [ADDR_WIDTH-1:0] result;
        step      = ADDR_ONE << size;
        wrap_mask = (ADDR_WIDTH'({1'b0, len} + 9'd1) << size) - ADDR_ONE;
        case (burst)
            BURST_FIXED: result = addr;
            BURST_INCR:  result = (addr & ~(step - ADDR_ONE)) + step;
            BURST_WRAP:  result = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
            default:     result = addr;
        endcase
        return result;
    endfunction

    // Errors that poison every beat of a burst, known at the address handshake
    function automatic logic req_error(
        input logic [2:0] size,
        input logic [1:0] burst,
        input logic [7:0] len
    );
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size > SIZE_MAX) || (burst == 2'b11) || ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >> BYTE_SHIFT) >= DEPTH_WORDS;
    endfunction

    function automatic logic [IDX_WIDTH-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
        return addr[IDX_WIDTH+BYTE_SHIFT-1:BYTE_SHIFT];
    endfunction

    // Write path state
    w_state_t              w_state_r;
    logic                  awready_r;
    logic                  wready_r;
    logic                  bvalid_r;
    logic [ID_WIDTH-1:0]   bid_r;
    logic [1:0]            bresp_r;
    logic [ID_WIDTH-1:0]   w_id_r;
    logic [ADDR_WIDTH-1:0] w_addr_r;
    logic [7:0]            w_len_r;
    logic [2:0]            w_size_r;
    logic [1:0]            w_burst_r;
    logic [7:0]            w_cnt_r;
    logic                  w_err_r;
    logic                  w_req_err_r;

    logic                  w_beat_s;
    logic                  w_oor_s;
    logic                  w_final_s;
    logic                  w_last_err_s;
    logic                  w_we_s;
    logic [IDX_WIDTH-1:0]  w_idx_s;

    // Read path state
    r_state_t              r_state_r;
    logic                  arready_r;
    logic                  rvalid_r;
    logic [ID_WIDTH-1:0]   rid_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic [1:0]            rresp_r;
    logic                  rlast_r;
    logic [ADDR_WIDTH-1:0] r_addr_r;
    logic [7:0]            r_len_r;
    logic [2:0]            r_size_r;
    logic [1:0]            r_burst_r;
    logic [7:0]            r_cnt_r;
    logic                  r_req_err_r;

    logic                  ar_req_err_s;
    logic [ADDR_WIDTH-1:0] r_next_addr_s;
    logic [ADDR_WIDTH-1:0] r_fetch_addr_s;
    logic                  r_fetch_err_s;
    logic [DATA_WIDTH-1:0] r_fetch_data_s;

    // Per-beat write qualifiers for the current W beat
    always_comb begin
        w_beat_s     = 1'b0;
        w_oor_s      = 1'b0;
        w_final_s    = 1'b0;
        w_last_err_s = 1'b0;
        w_we_s       = 1'b0;
        w_idx_s      = '0;
        w_beat_s     = (w_state_r == W_DATA) && wready_r && bus.WVALID;
        w_oor_s      = out_of_range(w_addr_r);
        w_final_s    = (w_cnt_r == w_len_r);
        w_last_err_s = (bus.WLAST != w_final_s);
        w_idx_s      = word_index(w_addr_r);
        w_we_s       = w_beat_s && !w_req_err_r && !w_oor_s;
    end

    // Write FSM: AW acceptance, beat counting, sticky error and B response
    always_ff @(posedge clk or negedge ARESET_n) begin
        if (!ARESET_n) begin
            w_state_r   <= W_IDLE;
            awready_r   <= 1'b0;
            wready_r    <= 1'b0;
            bvalid_r    <= 1'b0;
            bid_r       <= '0;
            bresp_r     <= RESP_OKAY;
            w_id_r      <= '0;
            w_addr_r    <= '0;
            w_len_r     <= 8'd0;
            w_size_r    <= 3'd0;
            w_burst_r   <= 2'b00;
            w_cnt_r     <= 8'd0;
            w_err_r     <= 1'b0;
            w_req_err_r <= 1'b0;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    if (awready_r && bus.AWVALID) begin
                        w_id_r      <= bus.AWID;
                        w_addr_r    <= bus.AWADDR;
                        w_len_r     <= bus.AWLEN;
                        w_size_r    <= bus.AWSIZE;
                        w_burst_r   <= bus.AWBURST;
                        w_cnt_r     <= 8'd0;
                        w_err_r     <= req_error(bus.AWSIZE, bus.AWBURST, bus.AWLEN);
                        w_req_err_r <= req_error(bus.AWSIZE, bus.AWBURST, bus.AWLEN);
                        awready_r   <= 1'b0;
                        wready_r    <= 1'b1;
                        w_state_r   <= W_DATA;
                    end else begin
                        awready_r   <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_beat_s) begin
                        w_addr_r <= next_addr(w_addr_r, w_size_r, w_burst_r, w_len_r);
                        w_cnt_r  <= w_cnt_r + 8'd1;
                        // Burst ends on the beat count; WLAST only feeds the error flag
                        if (w_final_s) begin
                            wready_r  <= 1'b0;
                            bvalid_r  <= 1'b1;
                            bid_r     <= w_id_r;
                            bresp_r   <= (w_err_r || w_oor_s || w_last_err_s) ? RESP_SLVERR : RESP_OKAY;
                            w_state_r <= W_RESP;
                        end else begin
                            w_err_r   <= w_err_r || w_oor_s || w_last_err_s;
                        end
                    end
                end
                W_RESP: begin
                    if (bus.BREADY) begin
                        bvalid_r  <= 1'b0;
                        bid_r     <= '0;
                        bresp_r   <= RESP_OKAY;
                        awready_r <= 1'b1;
                        w_state_r <= W_IDLE;
                    end
                end
                default: begin
                    awready_r <= 1'b0;
                    wready_r  <= 1'b0;
                    bvalid_r  <= 1'b0;
                    w_state_r <= W_IDLE;
                end
            endcase
        end
    end

    // Byte-lane RAM writes; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (w_we_s) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (bus.WSTRB[b]) begin
                    mem[w_idx_s][b*8 +: 8] <= bus.WDATA[b*8 +: 8];
                end
            end
        end
    end

    // Address and error of the beat the read FSM will load next
    always_comb begin
        ar_req_err_s   = 1'b0;
        r_next_addr_s  = '0;
        r_fetch_addr_s = '0;
        r_fetch_err_s  = 1'b0;
        r_fetch_data_s = '0;
        ar_req_err_s   = req_error(bus.ARSIZE, bus.ARBURST, bus.ARLEN);
        r_next_addr_s  = next_addr(r_addr_r, r_size_r, r_burst_r, r_len_r);
        r_fetch_addr_s = (r_state_r == R_IDLE) ? bus.ARADDR : r_next_addr_s;
        r_fetch_err_s  = ((r_state_r == R_IDLE) ? ar_req_err_s : r_req_err_r)
                         || out_of_range(r_fetch_addr_s);
        r_fetch_data_s = mem[word_index(r_fetch_addr_s)];
    end

    // Read FSM: RDATA is registered one beat ahead, so a same-cycle write is not seen
    always_ff @(posedge clk or negedge ARESET_n) begin
        if (!ARESET_n) begin
            r_state_r   <= R_IDLE;
            arready_r   <= 1'b0;
            rvalid_r    <= 1'b0;
            rid_r       <= '0;
            rdata_r     <= '0;
            rresp_r     <= RESP_OKAY;
            rlast_r     <= 1'b0;
            r_addr_r    <= '0;
            r_len_r     <= 8'd0;
            r_size_r    <= 3'd0;
            r_burst_r   <= 2'b00;
            r_cnt_r     <= 8'd0;
            r_req_err_r <= 1'b0;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (arready_r && bus.ARVALID) begin
                        rid_r       <= bus.ARID;
                        r_addr_r    <= bus.ARADDR;
                        r_len_r     <= bus.ARLEN;
                        r_size_r    <= bus.ARSIZE;
                        r_burst_r   <= bus.ARBURST;
                        r_cnt_r     <= 8'd0;
                        r_req_err_r <= ar_req_err_s;
                        rvalid_r    <= 1'b1;
                        rlast_r     <= (bus.ARLEN == 8'd0);
                        rdata_r     <= r_fetch_err_s ? '0 : r_fetch_data_s;
                        rresp_r     <= r_fetch_err_s ? RESP_SLVERR : RESP_OKAY;
                        arready_r   <= 1'b0;
                        r_state_r   <= R_DATA;
                    end else begin
                        arready_r   <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (bus.RREADY) begin
                        if (rlast_r) begin
                            rvalid_r  <= 1'b0;
                            rlast_r   <= 1'b0;
                            rid_r     <= '0;
                            rdata_r   <= '0;
                            rresp_r   <= RESP_OKAY;
                            arready_r <= 1'b1;
                            r_state_r <= R_IDLE;
                        end else begin
                            r_addr_r  <= r_next_addr_s;
                            r_cnt_r   <= r_cnt_r + 8'd1;
                            rlast_r   <= ((r_cnt_r + 8'd1) == r_len_r);
                            rdata_r   <= r_fetch_err_s ? '0 : r_fetch_data_s;
                            rresp_r   <= r_fetch_err_s ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                default: begin
                    arready_r <= 1'b0;
                    rvalid_r  <= 1'b0;
                    r_state_r <= R_IDLE;
                end
            endcase
        end
    end

    assign bus.AWREADY = awready_r;
    assign bus.WREADY  = wready_r;
    assign bus.BVALID  = bvalid_r;
    assign bus.BID     = bid_r;
    assign bus.BRESP   = bresp_r;
    assign bus.ARREADY = arready_r;
    assign bus.RVALID  = rvalid_r;
    assign bus.RID     = rid_r;
    assign bus.RDATA   = rdata_r;
    assign bus.RRESP   = rresp_r;
    assign bus.RLAST   = rlast_r;
endmodule

// File: tb/tb_axi4_slave_mem.sv
// Scoreboard bench for axi4_slave_mem: expected B/R results are queued as bursts
// are issued and popped as the DUT delivers them.
module tb_axi4_slave_mem;
    localparam int ID_WIDTH   = 4;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int MEM_DEPTH  = 1024;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } r_exp_t;

    typedef struct {
        logic [1:0] resp;
        logic [3:0] id;
    } b_exp_t;

    logic   clk;
    logic   ARESET_n;
    int     checks;
    int     errors;
    r_exp_t r_q[$];
    b_exp_t b_q[$];

    axi4_slave_mem_if #(.ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

    axi4_slave_mem #(
        .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH(MEM_DEPTH)
    ) dut (
        .clk(clk),
        .ARESET_n(ARESET_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_r(input logic [31:0] data, input logic [1:0] resp, input logic last, input logic [3:0] id);
        r_exp_t e;
        e.data = data; e.resp = resp; e.last = last; e.id = id;
        r_q.push_back(e);
    endtask

    task automatic push_b(input logic [1:0] resp, input logic [3:0] id);
        b_exp_t e;
        e.resp = resp; e.id = id;
        b_q.push_back(e);
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input logic [31:0] base, input logic [3:0] strb,
                               input int early_last, input int bready_hold);
        int     n;
        b_exp_t e;
        bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = 3'd2;
        bus.AWBURST = burst; bus.AWVALID = 1'b1;
        n = 0;
        while (!bus.AWREADY && n < 50) begin @(posedge clk); #1; n++; end
        check_val("awready", 64'(bus.AWREADY), 64'd1);
        @(posedge clk); #1;
        bus.AWVALID = 1'b0;
        check_val("wready_after_aw", 64'(bus.WREADY), 64'd1);
        for (int i = 0; i <= int'(len); i++) begin
            bus.WDATA  = base + 32'(i);
            bus.WSTRB  = strb;
            bus.WLAST  = (i == int'(len)) || (i == early_last);
            bus.WVALID = 1'b1;
            n = 0;
            while (!bus.WREADY && n < 50) begin @(posedge clk); #1; n++; end
            @(posedge clk); #1;
        end
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        check_val("bvalid_after_last_w", 64'(bus.BVALID), 64'd1);
        check_val("wready_after_last_w", 64'(bus.WREADY), 64'd0);
        for (int c = 0; c < bready_hold; c++) begin
            @(posedge clk); #1;
            check_val("bvalid_held", 64'(bus.BVALID), 64'd1);
            check_val("awready_during_b_stall", 64'(bus.AWREADY), 64'd0);
        end
        bus.BREADY = 1'b1;
        check_val("b_q_size", 64'(b_q.size()), 64'd1);
        if (b_q.size() > 0) begin
            e = b_q.pop_front();
            check_val("bresp", 64'(bus.BRESP), 64'(e.resp));
            check_val("bid", 64'(bus.BID), 64'(e.id));
        end
        @(posedge clk); #1;
        bus.BREADY = 1'b0;
        check_val("awready_after_b", 64'(bus.AWREADY), 64'd1);
        check_val("bvalid_after_b", 64'(bus.BVALID), 64'd0);
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic [3:0] pat);
        int          n;
        int          cyc;
        logic        done;
        logic        held_ok;
        logic [31:0] held;
        r_exp_t      e;
        bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = 3'd2;
        bus.ARBURST = burst; bus.ARVALID = 1'b1;
        n = 0;
        while (!bus.ARREADY && n < 50) begin @(posedge clk); #1; n++; end
        check_val("arready", 64'(bus.ARREADY), 64'd1);
        @(posedge clk); #1;
        bus.ARVALID = 1'b0;
        check_val("rvalid_after_ar", 64'(bus.RVALID), 64'd1);
        done = 1'b0; held_ok = 1'b0; held = 32'd0; cyc = 0;
        while (!done && cyc < 100) begin
            bus.RREADY = pat[cyc % 4];
            if (held_ok) check_val("rdata_stable", 64'(bus.RDATA), 64'(held));
            held_ok = 1'b0;
            if (bus.RVALID && bus.RREADY) begin
                if (r_q.size() > 0) begin
                    e = r_q.pop_front();
                    check_val("rdata", 64'(bus.RDATA), 64'(e.data));
                    check_val("rresp", 64'(bus.RRESP), 64'(e.resp));
                    check_val("rlast", 64'(bus.RLAST), 64'(e.last));
                    check_val("rid", 64'(bus.RID), 64'(e.id));
                end else begin
                    check_val("r_extra_beat", 64'(bus.RVALID), 64'd0);
                end
                done = bus.RLAST;
            end else if (bus.RVALID) begin
                held    = bus.RDATA;
                held_ok = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.RREADY = 1'b0;
        check_val("r_burst_done", 64'(done), 64'd1);
        check_val("r_q_drained", 64'(r_q.size()), 64'd0);
        check_val("arready_after_last_r", 64'(bus.ARREADY), 64'd1);
        check_val("rvalid_after_last_r", 64'(bus.RVALID), 64'd0);
    endtask

    initial begin
        int n;
        checks = 0; errors = 0;
        ARESET_n = 1'b0;
        bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0; bus.AWVALID = 1'b0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
        bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_awready", 64'(bus.AWREADY), 64'd0);
        check_val("rst_arready", 64'(bus.ARREADY), 64'd0);
        check_val("rst_wready", 64'(bus.WREADY), 64'd0);
        check_val("rst_bvalid", 64'(bus.BVALID), 64'd0);
        check_val("rst_rvalid", 64'(bus.RVALID), 64'd0);
        ARESET_n = 1'b1;
        @(posedge clk); #1;
        check_val("awready_first_edge", 64'(bus.AWREADY), 64'd1);
        check_val("arready_first_edge", 64'(bus.ARREADY), 64'd1);

        // INCR write then read back
        push_b(OKAY, 4'h1);
        write_burst(4'h1, 32'h10, 8'd3, INCR, 32'hA0, 4'hF, -1, 0);
        push_r(32'hA0, OKAY, 1'b0, 4'h2); push_r(32'hA1, OKAY, 1'b0, 4'h2);
        push_r(32'hA2, OKAY, 1'b0, 4'h2); push_r(32'hA3, OKAY, 1'b1, 4'h2);
        read_burst(4'h2, 32'h10, 8'd3, INCR, 4'b1111);

        // WRAP read over words 0x30..0x3C starting at 0x38
        push_b(OKAY, 4'h3);
        write_burst(4'h3, 32'h30, 8'd3, INCR, 32'hB0, 4'hF, -1, 0);
        push_r(32'hB2, OKAY, 1'b0, 4'h4); push_r(32'hB3, OKAY, 1'b0, 4'h4);
        push_r(32'hB0, OKAY, 1'b0, 4'h4); push_r(32'hB1, OKAY, 1'b1, 4'h4);
        read_burst(4'h4, 32'h38, 8'd3, WRAP, 4'b1111);

        // Byte strobes
        push_b(OKAY, 4'h5);
        write_burst(4'h5, 32'h40, 8'd0, INCR, 32'h11223344, 4'hF, -1, 0);
        push_b(OKAY, 4'h5);
        write_burst(4'h5, 32'h40, 8'd0, INCR, 32'hAABBCCDD, 4'b0101, -1, 0);
        push_r(32'h11BB33DD, OKAY, 1'b1, 4'h6);
        read_burst(4'h6, 32'h40, 8'd0, INCR, 4'b1111);

        // Out-of-range second beat
        push_b(SLVERR, 4'h7);
        write_burst(4'h7, 32'hFFC, 8'd1, INCR, 32'hC0, 4'hF, -1, 0);
        push_r(32'hC0, OKAY, 1'b0, 4'h8); push_r(32'h0, SLVERR, 1'b1, 4'h8);
        read_burst(4'h8, 32'hFFC, 8'd1, INCR, 4'b1111);

        // RREADY backpressure pattern 1,0,0,1
        push_r(32'hA0, OKAY, 1'b0, 4'h9); push_r(32'hA1, OKAY, 1'b0, 4'h9);
        push_r(32'hA2, OKAY, 1'b0, 4'h9); push_r(32'hA3, OKAY, 1'b1, 4'h9);
        read_burst(4'h9, 32'h10, 8'd3, INCR, 4'b1001);

        // Early WLAST: all four beats still taken and stored, response SLVERR
        push_b(SLVERR, 4'hA);
        write_burst(4'hA, 32'h50, 8'd3, INCR, 32'hD0, 4'hF, 1, 0);
        push_r(32'hD0, OKAY, 1'b0, 4'hB); push_r(32'hD1, OKAY, 1'b0, 4'hB);
        push_r(32'hD2, OKAY, 1'b0, 4'hB); push_r(32'hD3, OKAY, 1'b1, 4'hB);
        read_burst(4'hB, 32'h50, 8'd3, INCR, 4'b1111);

        // BREADY held low for five cycles
        push_b(OKAY, 4'hC);
        write_burst(4'hC, 32'h60, 8'd0, FIXED, 32'h66, 4'hF, -1, 5);

        // Illegal WRAP length suppresses the whole write burst
        push_b(OKAY, 4'hD);
        write_burst(4'hD, 32'h70, 8'd0, INCR, 32'h77, 4'hF, -1, 0);
        push_b(SLVERR, 4'hD);
        write_burst(4'hD, 32'h70, 8'd2, WRAP, 32'hE0, 4'hF, -1, 0);
        push_r(32'h77, OKAY, 1'b1, 4'hE);
        read_burst(4'hE, 32'h70, 8'd0, INCR, 4'b1111);

        // Reserved burst type: zero data with SLVERR on every beat
        push_r(32'h0, SLVERR, 1'b0, 4'hF); push_r(32'h0, SLVERR, 1'b1, 4'hF);
        read_burst(4'hF, 32'h10, 8'd1, 2'b11, 4'b1111);

        // Reset during beat 2 of an 8-beat read
        bus.ARID = 4'h7; bus.ARADDR = 32'h10; bus.ARLEN = 8'd7; bus.ARSIZE = 3'd2;
        bus.ARBURST = INCR; bus.ARVALID = 1'b1;
        n = 0;
        while (!bus.ARREADY && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus.ARVALID = 1'b0;
        bus.RREADY  = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("rvalid_beat2", 64'(bus.RVALID), 64'd1);
        ARESET_n   = 1'b0;
        bus.RREADY = 1'b0;
        #1;
        check_val("rvalid_in_reset", 64'(bus.RVALID), 64'd0);
        check_val("arready_in_reset", 64'(bus.ARREADY), 64'd0);
        check_val("awready_in_reset", 64'(bus.AWREADY), 64'd0);
        @(posedge clk); #1;
        ARESET_n = 1'b1;
        @(posedge clk); #1;
        check_val("arready_after_reset", 64'(bus.ARREADY), 64'd1);
        check_val("awready_after_reset", 64'(bus.AWREADY), 64'd1);
        for (int c = 0; c < 3; c++) begin
            check_val("no_stale_rvalid", 64'(bus.RVALID), 64'd0);
            check_val("no_stale_bvalid", 64'(bus.BVALID), 64'd0);
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
